// File: rtl/peripheral_gpio_apb4.sv
// APB slave GPIO block: per-pin direction, push-pull/open-drain drive, synchronised input, level/edge IRQ.
// Latency: register writes reach the pads right after the commit edge; pad input reaches irq_o after 4 edges.
// Backpressure: none; PREADY is tied high, so every transfer finishes in setup + access.
//
// Ports:
//   PCLK, PRESET            clock and synchronous active-high reset
//   PSEL..PSTRB, PWDATA     APB slave request (PSTRB = 0 suppresses a write)
//   PRDATA, PREADY, PSLVERR APB slave response
//   gpio_i                  asynchronous pad inputs
//   gpio_o, gpio_oe         pad output value and output enable
//   irq_o                   registered OR of the interrupt status register
//
// Register map (PADDR[2:0]; upper address bits must be zero):
//   0 MODE       0 = push-pull, 1 = open-drain
//   1 DIRECTION  1 = output
//   2 OUTPUT
//   3 INPUT      read-only, synchronised pad value
//   4 TR_TYPE    0 = level, 1 = edge
//   5 TR_POL     level: 1 = high-active; edge: 1 = rising, 0 = falling
//   6 IRQ_ENA
//   7 IRQ_STATUS read, write-1-to-clear

module peripheral_gpio_apb4 #(
    parameter int PADDR_SIZE = 10,
    parameter int PDATA_SIZE = 8
) (
    input  logic                  PCLK,
    input  logic                  PRESET,

    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic [PADDR_SIZE-1:0] PADDR,
    input  logic                  PWRITE,
    input  logic                  PSTRB,
    input  logic [PDATA_SIZE-1:0] PWDATA,
    output logic [PDATA_SIZE-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,

    input  logic [PDATA_SIZE-1:0] gpio_i,
    output logic [PDATA_SIZE-1:0] gpio_o,
    output logic [PDATA_SIZE-1:0] gpio_oe,

    output logic                  irq_o
);

    localparam logic [2:0] ADDR_MODE       = 3'd0;
    localparam logic [2:0] ADDR_DIRECTION  = 3'd1;
    localparam logic [2:0] ADDR_OUTPUT     = 3'd2;
    localparam logic [2:0] ADDR_INPUT      = 3'd3;
    localparam logic [2:0] ADDR_TR_TYPE    = 3'd4;
    localparam logic [2:0] ADDR_TR_POL     = 3'd5;
    localparam logic [2:0] ADDR_IRQ_ENA    = 3'd6;
    localparam logic [2:0] ADDR_IRQ_STATUS = 3'd7;

    // Software-visible state, kept together so reset clears it in one go.
    typedef struct packed {
        logic [PDATA_SIZE-1:0] mode;
        logic [PDATA_SIZE-1:0] direction;
        logic [PDATA_SIZE-1:0] output_r;
        logic [PDATA_SIZE-1:0] tr_type;
        logic [PDATA_SIZE-1:0] tr_pol;
        logic [PDATA_SIZE-1:0] irq_ena;
        logic [PDATA_SIZE-1:0] irq_status;
    } gpio_regs_t;

    gpio_regs_t            regs;

    logic [PDATA_SIZE-1:0] sync1;
    logic [PDATA_SIZE-1:0] sync2;
    logic [PDATA_SIZE-1:0] prev;

    logic [2:0]            reg_addr;
    logic                  access_phase;
    logic                  addr_hi_err;
    logic                  wr_ro_err;
    logic                  acc_err;
    logic                  reg_we;
    logic                  rd_sel;

    logic [PDATA_SIZE-1:0] w1c_mask;
    logic [PDATA_SIZE-1:0] level_hit;
    logic [PDATA_SIZE-1:0] rise;
    logic [PDATA_SIZE-1:0] fall;
    logic [PDATA_SIZE-1:0] edge_hit;
    logic [PDATA_SIZE-1:0] trig;
    logic [PDATA_SIZE-1:0] status_nxt;

    // ------------------------------------------------------------------
    // APB decode
    // ------------------------------------------------------------------
    assign reg_addr     = PADDR[2:0];
    assign access_phase = PSEL & PENABLE;
    assign addr_hi_err  = |PADDR[PADDR_SIZE-1:3];
    assign wr_ro_err    = PWRITE & (reg_addr == ADDR_INPUT);
    assign acc_err      = addr_hi_err | wr_ro_err;

    // Errored or strobe-less writes leave every register untouched.
    assign reg_we  = access_phase & PWRITE & PSTRB & ~acc_err;

    assign PREADY  = 1'b1;
    assign PSLVERR = access_phase & acc_err;

    // Read data is valid through both setup and access phases.
    assign rd_sel  = PSEL & ~PWRITE & ~addr_hi_err;

    always_comb begin
        PRDATA = '0;
        if (rd_sel) begin
            case (reg_addr)
                ADDR_MODE:       PRDATA = regs.mode;
                ADDR_DIRECTION:  PRDATA = regs.direction;
                ADDR_OUTPUT:     PRDATA = regs.output_r;
                ADDR_INPUT:      PRDATA = sync2;
                ADDR_TR_TYPE:    PRDATA = regs.tr_type;
                ADDR_TR_POL:     PRDATA = regs.tr_pol;
                ADDR_IRQ_ENA:    PRDATA = regs.irq_ena;
                ADDR_IRQ_STATUS: PRDATA = regs.irq_status;
                default:         PRDATA = '0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Pad drive: open-drain pins never drive high, they release instead.
    // ------------------------------------------------------------------
    assign gpio_o  = regs.output_r & ~regs.mode;
    assign gpio_oe = regs.direction & ~(regs.mode & regs.output_r);

    // ------------------------------------------------------------------
    // Interrupt triggers
    // ------------------------------------------------------------------
    assign level_hit = ~(sync2 ^ regs.tr_pol);
    assign rise      = sync2 & ~prev;
    assign fall      = ~sync2 & prev;
    assign edge_hit  = (regs.tr_pol & rise) | (~regs.tr_pol & fall);
    assign trig      = regs.irq_ena & ((~regs.tr_type & level_hit) | (regs.tr_type & edge_hit));

    assign w1c_mask  = (reg_we && (reg_addr == ADDR_IRQ_STATUS)) ? PWDATA : '0;

    // A trigger in the same cycle as a clear keeps the bit set.
    assign status_nxt = (regs.irq_status & ~w1c_mask) | trig;

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            regs <= '0;
        end else begin
            if (reg_we) begin
                case (reg_addr)
                    ADDR_MODE:      regs.mode      <= PWDATA;
                    ADDR_DIRECTION: regs.direction <= PWDATA;
                    ADDR_OUTPUT:    regs.output_r  <= PWDATA;
                    ADDR_TR_TYPE:   regs.tr_type   <= PWDATA;
                    ADDR_TR_POL:    regs.tr_pol    <= PWDATA;
                    ADDR_IRQ_ENA:   regs.irq_ena   <= PWDATA;
                    default:        ;
                endcase
            end
            regs.irq_status <= status_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Input synchroniser and edge history
    // ------------------------------------------------------------------
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= gpio_i;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    // ------------------------------------------------------------------
    // Interrupt output, one cycle behind the status register
    // ------------------------------------------------------------------
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            irq_o <= 1'b0;
        end else begin
            irq_o <= |regs.irq_status;
        end
    end

endmodule

// File: tb/tb_peripheral_gpio_apb4.sv
module tb_peripheral_gpio_apb4;

    localparam int AW = 10;
    localparam int DW = 8;

    logic          PCLK;
    logic          PRESET;
    logic          PSEL;
    logic          PENABLE;
    logic [AW-1:0] PADDR;
    logic          PWRITE;
    logic          PSTRB;
    logic [DW-1:0] PWDATA;
    logic [DW-1:0] PRDATA;
    logic          PREADY;
    logic          PSLVERR;
    logic [DW-1:0] gpio_i;
    logic [DW-1:0] gpio_o;
    logic [DW-1:0] gpio_oe;
    logic          irq_o;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] exp_q[$];
    string         tag_q[$];

    peripheral_gpio_apb4 #(.PADDR_SIZE(AW), .PDATA_SIZE(DW)) dut (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PADDR   (PADDR),
        .PWRITE  (PWRITE),
        .PSTRB   (PSTRB),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR),
        .gpio_i  (gpio_i),
        .gpio_o  (gpio_o),
        .gpio_oe (gpio_oe),
        .irq_o   (irq_o)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish (got running, need done)");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected read data goes into the scoreboard when the read is driven.
    task automatic sb_push(input string tag, input logic [DW-1:0] exp);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
    endtask

    // Called where PRDATA is valid: pops the oldest expectation and compares.
    task automatic sb_pop_chk();
        logic [DW-1:0] e;
        string         t;
        if (exp_q.size() == 0) begin
            chk("sb_underflow", 1, 0);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            chk(t, PRDATA, e);
        end
    endtask

    // All tasks start and end 1 ns after a rising edge.
    task automatic step(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    task automatic apb_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                             input logic strb, input logic exp_err, input string tag);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1;
        PADDR = addr; PWDATA = data; PSTRB = strb;
        step(1);
        PENABLE = 1'b1;
        @(negedge PCLK);
        chk({tag, "_slverr"}, PSLVERR, exp_err);
        chk({tag, "_ready"},  PREADY,  1'b1);
        step(1);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PSTRB = 1'b0;
    endtask

    task automatic apb_read(input logic [AW-1:0] addr, input logic [DW-1:0] exp,
                            input logic exp_err, input string tag);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = addr; PSTRB = 1'b0;
        sb_push(tag, exp);
        step(1);
        PENABLE = 1'b1;
        @(negedge PCLK);
        sb_pop_chk();
        chk({tag, "_slverr"}, PSLVERR, exp_err);
        chk({tag, "_ready"},  PREADY,  1'b1);
        step(1);
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    initial begin
        // ---------------- reset with random inputs ----------------
        PRESET  = 1'b1;
        PSEL    = 1'($urandom);
        PENABLE = 1'($urandom);
        PADDR   = AW'($urandom);
        PWRITE  = 1'($urandom);
        PSTRB   = 1'($urandom);
        PWDATA  = DW'($urandom);
        gpio_i  = DW'($urandom);
        step(2);
        @(negedge PCLK);
        chk("rst_gpio_oe", gpio_oe, 8'h00);
        chk("rst_gpio_o",  gpio_o,  8'h00);
        chk("rst_irq",     irq_o,   1'b0);
        chk("rst_ready",   PREADY,  1'b1);
        step(1);
        PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PSTRB = 1'b0;
        gpio_i = 8'h00;
        step(3);
        for (int a = 0; a < 8; a++)
            apb_read(AW'(a), 8'h00, 1'b0, $sformatf("rst_reg%0d", a));

        // ---------------- output drive ----------------
        apb_write(AW'(1), 8'hFF, 1'b1, 1'b0, "wr_dir");
        apb_write(AW'(2), 8'hA5, 1'b1, 1'b0, "wr_out");
        @(negedge PCLK);
        chk("pp_gpio_o",  gpio_o,  8'hA5);
        chk("pp_gpio_oe", gpio_oe, 8'hFF);
        step(1);
        apb_write(AW'(0), 8'h0F, 1'b1, 1'b0, "wr_mode");
        @(negedge PCLK);
        chk("od_gpio_o",  gpio_o,  8'hA0);
        chk("od_gpio_oe", gpio_oe, 8'hFA);
        step(1);

        // ---------------- input synchroniser ----------------
        gpio_i = 8'h3C;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = AW'(3);
        sb_push("in_before_k", 8'h00);
        @(negedge PCLK);
        sb_pop_chk();
        @(posedge PCLK);                       // edge k
        sb_push("in_after_k", 8'h00);
        @(negedge PCLK);
        sb_pop_chk();
        @(posedge PCLK);                       // edge k+1
        sb_push("in_after_k1", 8'h3C);
        @(negedge PCLK);
        sb_pop_chk();
        step(1);
        PSEL = 1'b0;
        apb_read(AW'(3), 8'h3C, 1'b0, "in_apb");

        // ---------------- edge interrupt ----------------
        apb_write(AW'(4), 8'h01, 1'b1, 1'b0, "wr_trtype");
        apb_write(AW'(5), 8'h01, 1'b1, 1'b0, "wr_trpol");
        apb_write(AW'(6), 8'h01, 1'b1, 1'b0, "wr_ena");
        gpio_i = 8'h3D;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = AW'(7);
        @(posedge PCLK);                       // k
        @(posedge PCLK);                       // k+1
        sb_push("edge_st_k1", 8'h00);
        @(negedge PCLK);
        sb_pop_chk();
        chk("edge_irq_k1", irq_o, 1'b0);
        @(posedge PCLK);                       // k+2
        sb_push("edge_st_k2", 8'h01);
        @(negedge PCLK);
        sb_pop_chk();
        chk("edge_irq_k2", irq_o, 1'b0);
        @(posedge PCLK);                       // k+3
        @(negedge PCLK);
        chk("edge_irq_k3", irq_o, 1'b1);
        step(1);
        PSEL = 1'b0;
        apb_write(AW'(7), 8'h01, 1'b1, 1'b0, "w1c_edge");
        @(negedge PCLK);
        chk("w1c_irq_still", irq_o, 1'b1);
        @(posedge PCLK);
        @(negedge PCLK);
        chk("w1c_irq_low", irq_o, 1'b0);
        step(1);
        apb_read(AW'(7), 8'h00, 1'b0, "w1c_status");
        gpio_i = 8'h3C;                        // falling edge: not selected
        step(5);
        apb_read(AW'(7), 8'h00, 1'b0, "fall_no_set");
        chk("fall_irq", irq_o, 1'b0);

        // ---------------- level interrupt, set beats clear ----------------
        apb_write(AW'(6), 8'h00, 1'b1, 1'b0, "wr_ena0");
        apb_write(AW'(4), 8'h00, 1'b1, 1'b0, "wr_trtype0");
        apb_write(AW'(5), 8'h02, 1'b1, 1'b0, "wr_trpol2");
        apb_write(AW'(6), 8'h02, 1'b1, 1'b0, "wr_ena2");
        gpio_i = 8'h3E;
        step(4);
        apb_read(AW'(7), 8'h02, 1'b0, "lvl_set");
        chk("lvl_irq", irq_o, 1'b1);
        apb_write(AW'(7), 8'h02, 1'b1, 1'b0, "lvl_w1c_held");
        apb_read(AW'(7), 8'h02, 1'b0, "lvl_set_wins");
        gpio_i = 8'h3C;
        step(4);
        apb_read(AW'(7), 8'h02, 1'b0, "lvl_sticky");
        apb_write(AW'(7), 8'h02, 1'b1, 1'b0, "lvl_w1c");
        apb_read(AW'(7), 8'h00, 1'b0, "lvl_cleared");
        chk("lvl_irq_low", irq_o, 1'b0);

        // ---------------- error handling ----------------
        apb_read(AW'(8), 8'h00, 1'b1, "err_rd_hi");
        apb_write(AW'(3), 8'hFF, 1'b1, 1'b1, "err_wr_input");
        apb_write(AW'(10), 8'h00, 1'b1, 1'b1, "err_wr_hi");
        apb_read(AW'(2), 8'hA5, 1'b0, "err_out_kept");
        apb_read(AW'(3), 8'h3C, 1'b0, "err_in_kept");
        apb_write(AW'(2), 8'h00, 1'b0, 1'b0, "nostrb_wr");
        apb_read(AW'(2), 8'hA5, 1'b0, "nostrb_out_kept");
        chk("nostrb_gpio_o", gpio_o, 8'hA0);

        // ---------------- reset mid-access ----------------
        gpio_i = 8'h3E;                        // level irq on bit 1 asserts again
        step(5);
        chk("pre_rst_irq", irq_o, 1'b1);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1;
        PADDR = AW'(2); PWDATA = 8'h5A; PSTRB = 1'b1;
        step(1);
        PENABLE = 1'b1;
        PRESET  = 1'b1;
        @(posedge PCLK);
        @(negedge PCLK);
        chk("mid_rst_gpio_o",  gpio_o,  8'h00);
        chk("mid_rst_gpio_oe", gpio_oe, 8'h00);
        chk("mid_rst_irq",     irq_o,   1'b0);
        chk("mid_rst_slverr",  PSLVERR, 1'b0);
        chk("mid_rst_ready",   PREADY,  1'b1);
        step(1);
        PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PSTRB = 1'b0;
        gpio_i = 8'h00;
        step(3);
        apb_read(AW'(2), 8'h00, 1'b0, "mid_rst_out");
        apb_read(AW'(1), 8'h00, 1'b0, "mid_rst_dir");
        apb_read(AW'(7), 8'h00, 1'b0, "mid_rst_status");
        chk("mid_rst_irq_after", irq_o, 1'b0);

        chk("sb_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
